// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU operation encodings
// and default datapath widths.
package alu_share_arbiter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CTRLW = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward with wrap and
// returns a one-hot grant plus its encoded index. The caller owns ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered ALU inputs, registered result returned two edges after accept.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CTRLW = DEF_CTRLW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CTRLW-1:0] req_ALUControl,
  input  logic [NREQ*WIDTH-1:0] req_rs,
  input  logic [NREQ*WIDTH-1:0] req_rt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_ALUresult,
  output logic [CTRLW-1:0]      ALUControl,
  output logic [WIDTH-1:0]      rs,
  output logic [WIDTH-1:0]      rt,
  input  logic [WIDTH-1:0]      ALUresult
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [CTRLW-1:0] ctrl_arr [NREQ];
  logic [WIDTH-1:0] rs_arr   [NREQ];
  logic [WIDTH-1:0] rt_arr   [NREQ];

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             any_grant;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [IW-1:0]    s1_id_q, s1_id_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign ctrl_arr[gi] = req_ALUControl[gi*CTRLW +: CTRLW];
    assign rs_arr[gi]   = req_rs[gi*WIDTH +: WIDTH];
    assign rt_arr[gi]   = req_rt[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Responses are never back-pressured, so the grant is the ready.
  assign req_ready = reset ? '0 : grant;
  assign any_grant = |req_ready;

  always_comb begin
    ptr_d       = ptr_q;
    ctrl_d      = ctrl_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    s1_valid_d  = any_grant;
    s1_id_d     = s1_id_q;
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    if (any_grant) begin
      ctrl_d  = ctrl_arr[grant_idx];
      rs_d    = rs_arr[grant_idx];
      rt_d    = rt_arr[grant_idx];
      s1_id_d = grant_idx;
      ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    // ALU inputs have been stable for a full cycle by now.
    if (s1_valid_q) begin
      rsp_valid_d = NREQ'(1) << s1_id_q;
      rsp_res_d   = ALUresult;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
    end
  end

  assign ALUControl    = ctrl_q;
  assign rs            = rs_q;
  assign rt            = rt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_ALUresult = rsp_res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU behind it: directed
// vector table, reset corner cases, then random traffic against a queue model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ALUControl;
  logic [63:0] req_rs, req_rt;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_ALUresult;
  logic [3:0]  ALUControl;
  logic [31:0] rs, rt, ALUresult;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_NOR: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign ALUresult = alu(ALUControl, rs, rt);

  alu_share_arbiter #(.NREQ(2), .WIDTH(32), .CTRLW(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ALUControl (req_ALUControl),
    .req_rs         (req_rs),
    .req_rt         (req_rt),
    .rsp_valid      (rsp_valid),
    .rsp_ALUresult  (rsp_ALUresult),
    .ALUControl     (ALUControl),
    .rs             (rs),
    .rt             (rt),
    .ALUresult      (ALUresult)
  );

  // Reference model: pending responses with the cycle they become visible.
  typedef struct {
    int          id;
    logic [31:0] res;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc      = 0;
  int          ptr      = 0;
  int          wait_cnt [2];
  logic [3:0]  m_ctrl   = '0;
  logic [31:0] m_rs     = '0;
  logic [31:0] m_rt     = '0;
  logic [31:0] m_res    = '0;
  logic [1:0]  seen_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    ptr = 0;
    m_ctrl = '0; m_rs = '0; m_rt = '0; m_res = '0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
  endtask

  task automatic do_reset(input int n, input logic [1:0] v);
    reset = 1'b1;
    req_valid = v;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_res", 64'(rsp_ALUresult), 64'(0));
      chk("rst_ctrl", 64'(ALUControl), 64'(0));
      chk("rst_rs", 64'(rs), 64'(0));
      chk("rst_rt", 64'(rt), 64'(0));
      $display("reset cycle %0d: ready=%b rsp_valid=%b", i, req_ready, rsp_valid);
    end
    reset = 1'b0;
    model_clear();
  endtask

  // One clock of traffic: drive, check ready, clock, check the registered side.
  task automatic step(input logic [1:0] v,
                      input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    int         g;
    int         jj;
    logic [1:0] er;
    logic [1:0] ev;
    req_valid      = v;
    req_ALUControl = {c1, c0};
    req_rs         = {a1, a0};
    req_rt         = {b1, b0};
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      jj = (ptr + k) % 2;
      if (g < 0 && v[jj]) g = jj;
    end
    er = (g >= 0) ? 2'(1 << g) : 2'b00;
    seen_ready = req_ready;
    chk("ready", 64'(req_ready), 64'(er));
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !er[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      chk("fair", 64'(wait_cnt[i] < 2), 64'(1));
    end
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      m_ctrl = (g == 1) ? c1 : c0;
      m_rs   = (g == 1) ? a1 : a0;
      m_rt   = (g == 1) ? b1 : b0;
      pend.push_back('{id: g, res: alu(m_ctrl, m_rs, m_rt), due: cyc + 1});
      ptr = (g + 1) % 2;
    end
    #1;
    ev = 2'b00;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev    = 2'(1 << pend[0].id);
      m_res = pend[0].res;
      void'(pend.pop_front());
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_res", 64'(rsp_ALUresult), 64'(m_res));
    chk("alu_ctrl", 64'(ALUControl), 64'(m_ctrl));
    chk("alu_rs", 64'(rs), 64'(m_rs));
    chk("alu_rt", 64'(rt), 64'(m_rt));
    $display("cyc %0d: valid=%b ready=%b rsp_valid=%b rsp=%0h", cyc, v, seen_ready, rsp_valid, rsp_ALUresult);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [3:0] pick_op(input int r);
    case (r % 6)
      0: return ALU_AND;
      1: return ALU_OR;
      2: return ALU_ADD;
      3: return ALU_SUB;
      4: return ALU_SLT;
      default: return ALU_NOR;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    req_valid = '0; req_ALUControl = '0; req_rs = '0; req_rt = '0;
    model_clear();

    // Reset held with both requesters asking.
    do_reset(3, 2'b11);

    // req0 = ADD 5+3 = 8, req1 = SUB 9-4 = 5 throughout the table.
    tbl[0]  = '{2'b11, 2'b01, 2'b00, 32'd0};
    tbl[1]  = '{2'b11, 2'b10, 2'b01, 32'd8};
    tbl[2]  = '{2'b11, 2'b01, 2'b10, 32'd5};
    tbl[3]  = '{2'b11, 2'b10, 2'b01, 32'd8};
    tbl[4]  = '{2'b00, 2'b00, 2'b10, 32'd5};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 32'd5};
    tbl[6]  = '{2'b10, 2'b10, 2'b00, 32'd5};
    tbl[7]  = '{2'b11, 2'b01, 2'b10, 32'd5};
    tbl[8]  = '{2'b10, 2'b10, 2'b01, 32'd8};
    tbl[9]  = '{2'b00, 2'b00, 2'b10, 32'd5};
    tbl[10] = '{2'b01, 2'b01, 2'b00, 32'd5};
    tbl[11] = '{2'b00, 2'b00, 2'b01, 32'd8};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 32'd8};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 32'd8};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 32'd8};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, ALU_ADD, 32'd5, 32'd3, ALU_SUB, 32'd9, 32'd4);
      chk("tbl_ready", 64'(seen_ready), 64'(tbl[i].rdy));
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(tbl[i].rv));
      chk("tbl_rsp_res", 64'(rsp_ALUresult), 64'(tbl[i].res));
    end
    // Idle gap: ALU ports still hold the last accepted op.
    chk("idle_ctrl", 64'(ALUControl), 64'(ALU_ADD));
    chk("idle_rs", 64'(rs), 64'(5));
    chk("idle_rt", 64'(rt), 64'(3));

    // Accept then reset before the response: no pulse, ptr back to 0.
    step(2'b01, ALU_ADD, 32'd7, 32'd7, ALU_SUB, 32'd1, 32'd1);
    do_reset(1, 2'b00);
    step(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    step(2'b11, ALU_ADD, 32'd1, 32'd2, ALU_SUB, 32'd3, 32'd4);
    chk("post_rst_grant0", 64'(seen_ready), 64'(2'b01));
    step(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
    step(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);

    // Random traffic; ops may change or be withdrawn while waiting.
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)),
           pick_op(int'($urandom_range(0, 5))), $urandom, $urandom_range(0, 40),
           pick_op(int'($urandom_range(0, 5))), $urandom_range(0, 40), $urandom);
    end
    for (int i = 0; i < 3; i++)
      step(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
    chk("drained", 64'(pend.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
